// File: rtl/configure.sv
// Shared definitions for the Avalon-MM RAM responder.
// Holds the Avalon response codes, the responder FSM state type and two
// small helpers used by the datapath.
package configure;

  localparam logic [1:0] avl_resp_okay   = 2'b00;
  localparam logic [1:0] avl_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WBURST,
    RBURST,
    WRESP
  } avl_ram_state_t;

  // A burstcount of zero is served as a single beat.
  function automatic logic [2:0] avl_burst_len(input logic [2:0] burstcount);
    return (burstcount == 3'd0) ? 3'd1 : burstcount;
  endfunction

  function automatic logic [1:0] avl_resp_of(input logic err);
    return err ? avl_resp_slverr : avl_resp_okay;
  endfunction

endpackage

// File: rtl/avl_ram_mem.sv
// Single-port 32-bit RAM with four byte lanes, written in the plain
// template FPGA tools map onto block RAM (M9K/M10K).
// Latency: synchronous read, data valid one cycle after the address.
// Backpressure: none; read-during-write on the same address returns old data.
// Ports:
//   i_clock  - clock
//   i_addr   - word address
//   i_we     - write strobe, qualified per lane by i_be
//   i_be     - byte-lane write enables
//   i_wdata  - write data
//   o_rdata  - registered read data
module avl_ram_mem #(
  parameter int depth_log2 = 12
) (
  input  logic                  i_clock,
  input  logic [depth_log2-1:0] i_addr,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [3:0][7:0] r_mem [0:(1<<depth_log2)-1];
  logic [31:0]     r_rdata;

  // No reset on the array or the read register, otherwise the tools
  // fall back to logic cells instead of a memory block.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][b] <= i_wdata[8*b +: 8];
        end
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avl_ram.sv
// Avalon-MM responder backed by a local byte-enabled RAM, with incrementing bursts.
// Latency: write response 1 cycle after the last beat; read beat k 2+k cycles after the command.
// Backpressure: waitrequest held high through read bursts, the write response cycle and reset.
// Ports:
//   reset, clock               - asynchronous active-high reset, single clock
//   s_avl_address              - byte address, bits [1:0] ignored
//   s_avl_byteenable           - per-byte write enables
//   s_avl_lock                 - accepted and ignored
//   s_avl_read / s_avl_write   - command strobes; writedata is the write beat
//   s_avl_burstcount           - beats per burst, sampled on the first beat
//   s_avl_readdata             - read data, zero outside valid beats
//   s_avl_response             - OKAY / SLAVEERROR for read beats and write bursts
//   s_avl_waitrequest          - stall
//   s_avl_readdatavalid        - one pulse per read beat
//   s_avl_writeresponsevalid   - one pulse per write burst
module avl_ram
  import configure::*;
#(
  parameter int depth_log2 = 12
) (
  input  logic        reset,
  input  logic        clock,
  input  logic [31:0] s_avl_address,
  input  logic [3:0]  s_avl_byteenable,
  input  logic        s_avl_lock,
  input  logic        s_avl_read,
  input  logic        s_avl_write,
  input  logic [31:0] s_avl_writedata,
  input  logic [2:0]  s_avl_burstcount,
  output logic [31:0] s_avl_readdata,
  output logic [1:0]  s_avl_response,
  output logic        s_avl_waitrequest,
  output logic        s_avl_readdatavalid,
  output logic        s_avl_writeresponsevalid
);

  avl_ram_state_t r_state;
  logic [29:0]    r_base;     // word address of beat 0
  logic [2:0]     r_cnt;      // beat counter
  logic [2:0]     r_len;      // burst length, already normalised
  logic           r_err;      // sticky out-of-range flag for a write burst
  logic           r_rdvalid;
  logic           r_wrvalid;
  logic [1:0]     r_resp;

  logic [30:0]    w_word;
  logic           w_oor;
  logic [2:0]     w_len_in;
  logic           w_wr_beat;
  logic           w_ram_we;
  logic [31:0]    w_ram_q;
  logic           w_unused;

  // Word address of the beat being served. In IDLE it comes straight from
  // the bus so beat 0 of a write lands on the accepting edge. The extra top
  // bit catches carry out of the 30-bit word space, so a burst that runs
  // off the end is flagged instead of aliasing back to word 0.
  always_comb begin
    w_word = {1'b0, s_avl_address[31:2]};
    if (r_state != IDLE) begin
      w_word = {1'b0, r_base} + {28'd0, r_cnt};
    end
  end

  assign w_oor     = |w_word[30:depth_log2];
  assign w_len_in  = avl_burst_len(s_avl_burstcount);
  assign w_wr_beat = !reset && s_avl_write && ((r_state == IDLE) || (r_state == WBURST));
  assign w_ram_we  = w_wr_beat && !w_oor;

  avl_ram_mem #(
    .depth_log2 (depth_log2)
  ) u_mem (
    .i_clock (clock),
    .i_addr  (w_word[depth_log2-1:0]),
    .i_we    (w_ram_we),
    .i_be    (s_avl_byteenable),
    .i_wdata (s_avl_writedata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_cnt     <= '0;
      r_len     <= 3'd1;
      r_err     <= 1'b0;
      r_rdvalid <= 1'b0;
      r_wrvalid <= 1'b0;
      r_resp    <= avl_resp_okay;
    end else begin
      r_rdvalid <= 1'b0;
      r_wrvalid <= 1'b0;
      r_resp    <= avl_resp_okay;
      case (r_state)
        IDLE: begin
          // A write wins over a simultaneous read; the read is dropped.
          if (s_avl_write) begin
            r_base <= w_word[29:0];
            r_len  <= w_len_in;
            r_cnt  <= 3'd1;
            r_err  <= w_oor;
            if (w_len_in == 3'd1) begin
              r_state   <= WRESP;
              r_wrvalid <= 1'b1;
              r_resp    <= avl_resp_of(w_oor);
            end else begin
              r_state <= WBURST;
            end
          end else if (s_avl_read) begin
            r_base  <= w_word[29:0];
            r_len   <= w_len_in;
            r_cnt   <= 3'd0;
            r_state <= RBURST;
          end
        end

        WBURST: begin
          if (s_avl_write) begin
            r_cnt <= r_cnt + 3'd1;
            r_err <= r_err | w_oor;
            if (r_cnt == r_len - 3'd1) begin
              r_state   <= WRESP;
              r_wrvalid <= 1'b1;
              r_resp    <= avl_resp_of(r_err | w_oor);
            end
          end
        end

        WRESP: begin
          r_state <= IDLE;
        end

        RBURST: begin
          // Counts 0..len-1 issue RAM reads; count len is the cycle the
          // last beat is on the bus, after which the bus is released.
          if (r_cnt != r_len) begin
            r_cnt     <= r_cnt + 3'd1;
            r_rdvalid <= 1'b1;
            r_resp    <= avl_resp_of(w_oor);
          end else begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_avl_waitrequest        = reset || (r_state == RBURST) || (r_state == WRESP);
  assign s_avl_readdatavalid      = r_rdvalid;
  assign s_avl_writeresponsevalid = r_wrvalid;
  assign s_avl_response           = r_resp;
  // Out-of-range beats and idle cycles present zero rather than stale RAM output.
  assign s_avl_readdata = (r_rdvalid && (r_resp == avl_resp_okay)) ? w_ram_q : 32'd0;

  assign w_unused = &{1'b0, s_avl_lock, s_avl_address[1:0]};

endmodule

// File: tb/tb_avl_ram.sv
// Directed bench for avl_ram: stimulus pushes expected responses into
// queues, an independent monitor pops and compares on every valid pulse,
// including the exact cycle each response is due.
module tb_avl_ram;

  logic        reset = 1'b1;
  logic        clock = 1'b0;
  logic [31:0] s_avl_address = '0;
  logic [3:0]  s_avl_byteenable = '0;
  logic        s_avl_lock = 1'b0;
  logic        s_avl_read = 1'b0;
  logic        s_avl_write = 1'b0;
  logic [31:0] s_avl_writedata = '0;
  logic [2:0]  s_avl_burstcount = '0;
  logic [31:0] s_avl_readdata;
  logic [1:0]  s_avl_response;
  logic        s_avl_waitrequest;
  logic        s_avl_readdatavalid;
  logic        s_avl_writeresponsevalid;

  avl_ram #(.depth_log2(12)) dut (
    .reset                    (reset),
    .clock                    (clock),
    .s_avl_address            (s_avl_address),
    .s_avl_byteenable         (s_avl_byteenable),
    .s_avl_lock               (s_avl_lock),
    .s_avl_read               (s_avl_read),
    .s_avl_write              (s_avl_write),
    .s_avl_writedata          (s_avl_writedata),
    .s_avl_burstcount         (s_avl_burstcount),
    .s_avl_readdata           (s_avl_readdata),
    .s_avl_response           (s_avl_response),
    .s_avl_waitrequest        (s_avl_waitrequest),
    .s_avl_readdatavalid      (s_avl_readdatavalid),
    .s_avl_writeresponsevalid (s_avl_writeresponsevalid)
  );

  always #5 clock = ~clock;

  // Edge counter: at a falling edge, cyc is the number of rising edges so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    int          c;
  } rd_exp_t;

  typedef struct {
    logic [1:0] r;
    int         c;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wdat  [8];
  logic [31:0] exp_d [8];
  logic [1:0]  exp_r [8];

  // Monitor: compares every response against the scoreboard.
  rd_exp_t re;
  wr_exp_t we;
  always @(negedge clock) begin
    if (!reset) begin
      if (s_avl_readdatavalid) begin
        n_checks++;
        if (rd_q.size() == 0) begin
          n_errors++;
          $display("FAIL rd_unexpected got data=%h resp=%b cyc=%0d, no beat expected",
                   s_avl_readdata, s_avl_response, cyc);
        end else begin
          re = rd_q.pop_front();
          if (s_avl_readdata !== re.d || s_avl_response !== re.r || cyc != re.c) begin
            n_errors++;
            $display("FAIL rd_beat got data=%h resp=%b cyc=%0d, expected data=%h resp=%b cyc=%0d",
                     s_avl_readdata, s_avl_response, cyc, re.d, re.r, re.c);
          end
          n_checks++;
          if (s_avl_waitrequest !== 1'b1) begin
            n_errors++;
            $display("FAIL rd_waitrequest got %b during beat at cyc=%0d, expected 1",
                     s_avl_waitrequest, cyc);
          end
        end
      end
      if (s_avl_writeresponsevalid) begin
        n_checks++;
        if (wr_q.size() == 0) begin
          n_errors++;
          $display("FAIL wr_unexpected got resp=%b cyc=%0d, no response expected",
                   s_avl_response, cyc);
        end else begin
          we = wr_q.pop_front();
          if (s_avl_response !== we.r || cyc != we.c) begin
            n_errors++;
            $display("FAIL wr_resp got resp=%b cyc=%0d, expected resp=%b cyc=%0d",
                     s_avl_response, cyc, we.r, we.c);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Drive one beat; t returns the rising edge number that accepted it.
  task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be,
                       input logic [2:0] bc, output int t);
    int waited = 0;
    @(negedge clock);
    s_avl_write      = wr;
    s_avl_read       = rd;
    s_avl_address    = addr;
    s_avl_writedata  = data;
    s_avl_byteenable = be;
    s_avl_burstcount = bc;
    while (s_avl_waitrequest && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (s_avl_waitrequest) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout addr=%h waitrequest got 1 for 100 cycles, expected 0", addr);
      t = -1;
    end else begin
      t = cyc + 1;
      @(posedge clock);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    s_avl_write = 1'b0;
    s_avl_read  = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int n, input logic [2:0] bc,
                          input logic [3:0] be, input int stall_after, input int stall_n,
                          input logic [1:0] resp, output int t);
    wr_exp_t e;
    t = -1;
    for (int k = 0; k < n; k++) begin
      issue(1'b1, 1'b0, addr, wdat[k], be, bc, t);
      if (k == stall_after) begin
        for (int s = 0; s < stall_n; s++) idle();
      end
    end
    if (t >= 0) begin
      e.r = resp;
      e.c = t;
      wr_q.push_back(e);
    end
    idle();
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [2:0] bc,
                          input int npush, output int t);
    rd_exp_t e;
    issue(1'b0, 1'b1, addr, 32'd0, 4'hF, bc, t);
    if (t >= 0) begin
      for (int k = 0; k < npush; k++) begin
        e.d = exp_d[k];
        e.r = exp_r[k];
        e.c = t + 1 + k;
        rd_q.push_back(e);
      end
    end
    idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int tw, tr, t1, t2, guard;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_waitrequest", {31'd0, s_avl_waitrequest}, 32'd1);
    chk("reset_rdvalid", {31'd0, s_avl_readdatavalid}, 32'd0);
    chk("reset_wrvalid", {31'd0, s_avl_writeresponsevalid}, 32'd0);
    chk("reset_readdata", s_avl_readdata, 32'd0);
    chk("reset_response", {30'd0, s_avl_response}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_waitrequest", {31'd0, s_avl_waitrequest}, 32'd0);

    // Single write then read, back-to-back
    wdat[0] = 32'hDEADBEEF;
    wr_burst(32'h100, 1, 3'd1, 4'hF, -1, 0, 2'b00, tw);
    exp_d[0] = 32'hDEADBEEF; exp_r[0] = 2'b00;
    rd_burst(32'h100, 3'd1, 1, tr);
    chk("wr_then_rd_accept_edge", tr, tw + 2);

    // Byte-enable merge
    wdat[0] = 32'h11223344;
    wr_burst(32'h104, 1, 3'd1, 4'hF, -1, 0, 2'b00, tw);
    wdat[0] = 32'hAABBCCDD;
    wr_burst(32'h104, 1, 3'd1, 4'b0101, -1, 0, 2'b00, tw);
    exp_d[0] = 32'h11BB33DD; exp_r[0] = 2'b00;
    rd_burst(32'h104, 3'd1, 1, tr);

    // Burst of 4 with a two-cycle stall after the second beat
    for (int k = 0; k < 4; k++) wdat[k] = k + 1;
    wr_burst(32'h200, 4, 3'd4, 4'hF, 1, 2, 2'b00, tw);
    for (int k = 0; k < 4; k++) begin exp_d[k] = k + 1; exp_r[k] = 2'b00; end
    rd_burst(32'h200, 3'd4, 4, t1);

    // Out of range read, right after the burst completes
    exp_d[0] = 32'd0; exp_r[0] = 2'b10;
    rd_burst(32'h00004000, 3'd1, 1, t2);
    chk("rd_burst_then_rd_accept_edge", t2, t1 + 6);

    // Write burst straddling the top of memory
    wdat[0] = 32'hCAFEF00D; wdat[1] = 32'h12345678;
    wr_burst(32'h3FFC, 2, 3'd2, 4'hF, -1, 0, 2'b10, tw);
    exp_d[0] = 32'hCAFEF00D; exp_r[0] = 2'b00;
    exp_d[1] = 32'd0;        exp_r[1] = 2'b10;
    rd_burst(32'h3FFC, 3'd2, 2, tr);

    // burstcount 0 behaves as a single beat
    exp_d[0] = 32'hDEADBEEF; exp_r[0] = 2'b00;
    rd_burst(32'h100, 3'd0, 1, t1);
    exp_d[0] = 32'h11BB33DD; exp_r[0] = 2'b00;
    rd_burst(32'h104, 3'd1, 1, t2);
    chk("bc0_next_accept_edge", t2, t1 + 3);

    // byteenable 0000 consumes the beat without touching memory
    wdat[0] = 32'hFFFFFFFF;
    wr_burst(32'h100, 1, 3'd1, 4'b0000, -1, 0, 2'b00, tw);
    exp_d[0] = 32'hDEADBEEF; exp_r[0] = 2'b00;
    rd_burst(32'h100, 3'd1, 1, tr);

    // Reset during the third beat of a 4-beat read
    for (int k = 0; k < 3; k++) begin exp_d[k] = k + 1; exp_r[k] = 2'b00; end
    rd_burst(32'h200, 3'd4, 3, t1);
    guard = 0;
    while (cyc != t1 + 3 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    #2 reset = 1'b1;
    #1;
    chk("midreset_rdvalid", {31'd0, s_avl_readdatavalid}, 32'd0);
    chk("midreset_readdata", s_avl_readdata, 32'd0);
    chk("midreset_waitrequest", {31'd0, s_avl_waitrequest}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("after_reset_waitrequest", {31'd0, s_avl_waitrequest}, 32'd0);
    exp_d[0] = 32'h11BB33DD; exp_r[0] = 2'b00;
    rd_burst(32'h104, 3'd1, 1, tr);
    for (int k = 0; k < 4; k++) begin exp_d[k] = k + 1; exp_r[k] = 2'b00; end
    rd_burst(32'h200, 3'd4, 4, tr);

    // Every expected response must have arrived
    repeat (12) @(negedge clock);
    chk("rd_queue_drained", rd_q.size(), 32'd0);
    chk("wr_queue_drained", wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avl_ram.md
# avl_ram

Avalon-MM responder with local byte-enabled RAM. It answers the 32-bit Avalon master port the SoC drives out (`m_avl_*`), so it serves as the on-chip backing store at the far end of that interface. It is also the bench model for the Avalon bridge. It supports linear incrementing bursts, per-byte writes, per-beat read responses, one write response per burst, and SLAVEERROR for out-of-range addresses.

## Interface
- `depth_log2`, default 12: RAM depth is 2^depth_log2 32-bit words (default 16 KiB).
- `reset`  in  1: asynchronous, active-high.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `s_avl_address`  in  32: byte address; bits [1:0] are ignored.
- `s_avl_byteenable`  in  4: per-byte write enable. Ignored for reads.
- `s_avl_lock`  in  1: accepted and ignored (single master).
- `s_avl_read`  in  1: read command.
- `s_avl_write`  in  1: write beat.
- `s_avl_writedata`  in  32: write data.
- `s_avl_burstcount`  in  3: beats per burst. Sampled on the first beat only. 0 is treated as 1.
- `s_avl_readdata`  out  32: read data. Reset value 0.
- `s_avl_response`  out  2: 00 OKAY, 10 SLAVEERROR. Reset value 00.
- `s_avl_waitrequest`  out  1: forced to 1 while `reset` is high.
- `s_avl_readdatavalid`  out  1: reset value 0.
- `s_avl_writeresponsevalid`  out  1: reset value 0.

## Operation
- **Address mapping**
  - word index = address[depth_log2+1:2], incremented by 1 per beat.
  - A beat is out of range if address[31:depth_log2+2] is nonzero after incrementing.
  - An out-of-range write beat writes nothing.
  - An out-of-range read beat returns readdata 0 with response 10.
- **States**
  - IDLE: waitrequest=0.
  - WBURST: waitrequest=0.
  - RBURST: waitrequest=1.
  - WRESP: waitrequest=1.
- **IDLE**
  - write=1: beat 0 is accepted and written this edge. Address, count, and error flag are latched. beat counter=1.
    - count==1 → WRESP.
    - otherwise → WBURST.
  - read=1 and write=0: address and count are latched → RBURST.
  - read=1 and write=1 together is a master violation. The write is served and the read is dropped.
- **WBURST**
  - Each cycle with write=1 accepts one beat at base+beat. The beat counter increments.
  - The last beat → WRESP.
  - write=0 holds the state indefinitely. read is ignored.
- **WRESP**: one cycle with writeresponsevalid=1. response=10 if any beat of the burst was out of range, else 00. → IDLE.
- **RBURST**
  - Issues one RAM read per cycle for beats 0..count-1.
  - Each read produces readdatavalid=1 with its per-beat response exactly one cycle later.
  - → IDLE on the cycle the last beat's readdatavalid is asserted.
- **byteenable**: byteenable=0000 still consumes the beat but modifies no byte.
- **Reset mid-burst**: state → IDLE and both valid outputs → 0 immediately. The remaining beats are abandoned. RAM contents are not reset.
- **Address wrap**: if the word index overflows inside a burst, the affected beats are flagged out of range. They never alias to low memory.

## Timing
- **Read**: command accepted at edge T.
  - Beat k has readdatavalid high in cycle T+2+k, contiguous with no gaps.
  - waitrequest is high from T+1 through the last beat.
  - A new command can be accepted in the cycle after the last beat.
- **Single write**: accepted at edge T; writeresponsevalid high in cycle T+1; next command accepted at T+2.
- **Burst write**: the response comes in the cycle after the last beat is accepted.
- **Registers**: readdatavalid and writeresponsevalid are registered outputs. waitrequest is decoded from the state register plus `reset`.

## Structure
- Add to package `configure`:
  - `avl_resp_okay` = 2'b00.
  - `avl_resp_slverr` = 2'b10.
  - enum `avl_ram_state_t` {IDLE, WBURST, RBURST, WRESP}.
- Sub-module `avl_ram_mem`: single-port RAM, 2^depth_log2 × 32, 4 byte lanes, synchronous read with 1-cycle latency, read-during-write returns old data. It must be coded so Quartus infers an M9K/M10K block.
- FSM, beat counter (3 bits), latched base index, and error flag live in `avl_ram`.

## Test plan
- **Single write then read**: write 0x100 ← 0xDEADBEEF, be=1111.
  - writeresponsevalid at T+1, response 00.
  - read 0x100 → readdatavalid at T+2, data 0xDEADBEEF.
- **Byte-enable merge**: write 0x104 ← 0x11223344 with be=1111, then ← 0xAABBCCDD with be=0101. Read → 0x11BB33DD.
- **Burst of 4 write with a stall**: write 0x200..0x20C ← 1, 2, 3, 4, with write=0 for two cycles after beat 1.
  - One writeresponsevalid, response 00.
  - Read burst of 4 → readdatavalid in 4 consecutive cycles with data 1, 2, 3, 4, and waitrequest high throughout.
- **Out of range, default depth**: read 0x00004000 → readdata 0, response 10. Write burst of 2 at 0x3FFC → word 0x3FFC written, response 10.
- **burstcount=0**: a read returns exactly one beat.
- **Reset mid-burst**: assert reset during beat 2 of a 4-beat read.
  - readdatavalid drops the same cycle.
  - After release: waitrequest=0, IDLE, a fresh read is served correctly, and the RAM retains its data.
